// File: rtl/est_seq_ctrl_pkg.sv
// Shared types and constants for the CP-based timing/CFO estimator sequencer.
// Package name data_type is what the estimator datapath already imports.
package data_type;

   localparam int N             = 256;
   localparam int L             = 16;
   localparam int PIPE_DELAY    = 12;
   localparam int FIRST_SAMPLES = 2*N + L;

   localparam int THETA_W = $clog2(N);
   localparam int EPS_W   = 16;
   localparam int SYM_W   = 16;

   typedef logic        [THETA_W-1:0] theta_t;
   typedef logic signed [EPS_W-1:0]   eps_t;
   typedef logic        [SYM_W-1:0]   sym_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FILL,
      TRACK,
      DRAIN
   } est_state_e;

   typedef struct packed {
      theta_t theta;
      eps_t   eps;
      sym_t   sym;
   } res_t;

endpackage

// File: rtl/est_seq_ctrl_if.sv
// Result channel of the estimator sequencer: valid/ready with theta, epsilon
// and window index of the head entry.
interface est_seq_ctrl_if;
   import data_type::*;

   logic   res_valid;
   logic   res_ready;
   theta_t res_theta;
   eps_t   res_eps;
   sym_t   res_sym;

   modport master (
      output res_valid,
      output res_theta,
      output res_eps,
      output res_sym,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_theta,
      input  res_eps,
      input  res_sym,
      output res_ready
   );

endinterface

// File: rtl/est_res_fifo.sv
// Two-entry result FIFO; a push that coincides with a pop is always accepted,
// a push into a full FIFO without a pop is dropped and flagged on drop.
module est_res_fifo
   import data_type::*;
(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  res_t push_data,
   input  logic ready,
   output logic valid,
   output res_t head,
   output logic drop
);

   res_t       mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       full;
   logic       pop;
   logic       wr_ok;

   always_comb begin
      valid = (count != 2'd0);
      full  = (count == 2'd2);
      pop   = valid & ready;
      wr_ok = push & (~full | pop);
      drop  = push & full & ~pop;
      head  = mem[rd_ptr];
   end

   // When full, wr_ptr == rd_ptr: a simultaneous push reuses the slot being popped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({wr_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/est_seq_ctrl.sv
// Acquisition sequencer for the ML timing/CFO estimator: FSM, sample/window
// counters, result delay pipe. Optional macro: EST_SEQ_CTRL_EPS_AVG_EN.
module est_seq_ctrl
   import data_type::*;
#(
   parameter int N          = data_type::N,
   parameter int L          = data_type::L,
   parameter int PIPE_DELAY = data_type::PIPE_DELAY,
   parameter int NUM_SYM    = 0
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  logic   abort,
   input  logic   in_valid,
   input  theta_t theta_in,
   input  eps_t   eps_in,
   output logic   dp_clr,
   output logic   dp_en,
   output logic   win_last,
   output logic   busy,
   output logic   done,
   output logic   overrun,
   est_seq_ctrl_if.master res
);

   localparam int               FIRST      = 2*N + L;
   localparam int               CNT_W      = $clog2(FIRST);
   localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST - 1);
   localparam logic [CNT_W-1:0] WIN_MASK   = CNT_W'(N - 1);
   localparam sym_t             NUM_SYM_V  = SYM_W'(NUM_SYM);

   est_state_e            state;
   est_state_e            state_d;
   logic [CNT_W-1:0]      sample_cnt;
   sym_t                  win_cnt;
   sym_t                  cap_idx;
   logic [PIPE_DELAY-1:0] pipe;
   logic                  pipe_out;
   logic                  win_end;
   logic                  last_win;
   logic                  kill;
   logic                  push;
   logic                  drop;
   res_t                  push_data;
   res_t                  head;

   assign busy     = (state != IDLE);
   assign pipe_out = pipe[PIPE_DELAY-1];

   always_comb begin
      state_d  = state;
      dp_clr   = 1'b0;
      dp_en    = 1'b0;
      done     = 1'b0;
      win_end  = 1'b0;
      kill     = abort && (state != IDLE);
      last_win = (NUM_SYM != 0) && ((win_cnt + 16'd1) == NUM_SYM_V);
      case (state)
         IDLE:  if (start && !abort) state_d = CLEAR;
         CLEAR: begin
            dp_clr  = 1'b1;
            state_d = FILL;
         end
         FILL: begin
            dp_en = in_valid;
            if (in_valid && sample_cnt == FIRST_LAST) begin
               win_end = 1'b1;
               state_d = last_win ? DRAIN : TRACK;
            end
         end
         TRACK: begin
            dp_en = in_valid;
            if (in_valid && (sample_cnt & WIN_MASK) == WIN_MASK) begin
               win_end = 1'b1;
               if (last_win) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!win_last && pipe == '0) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (kill) begin
         state_d = IDLE;
         win_end = 1'b0;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         sample_cnt <= '0;
         win_cnt    <= '0;
         cap_idx    <= '0;
         pipe       <= '0;
         win_last   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state    <= state_d;
         win_last <= win_end;
         if (state == CLEAR || kill) pipe <= '0;
         else                        pipe <= (pipe << 1) | PIPE_DELAY'(win_last);
         if (state == CLEAR) begin
            sample_cnt <= '0;
            win_cnt    <= '0;
            cap_idx    <= '0;
            overrun    <= 1'b0;
         end else begin
            // TRACK lets the counter wrap; only its low log2(N) bits matter there.
            if (dp_en)
               sample_cnt <= (state == FILL && sample_cnt == FIRST_LAST) ? '0
                                                                        : sample_cnt + CNT_W'(1);
            if (win_end)           win_cnt <= win_cnt + 16'd1;
            if (pipe_out && !kill) cap_idx <= cap_idx + 16'd1;
            if (drop)              overrun <= 1'b1;
         end
      end
   end

`ifdef EST_SEQ_CTRL_EPS_AVG_EN
   logic signed [EPS_W+1:0] acc;
   logic signed [EPS_W+1:0] acc_sum;
   logic [1:0]              grp;

   always_comb begin
      acc_sum         = acc + (EPS_W+2)'(eps_in);
      push_data.theta = theta_in;
      push_data.eps   = eps_t'(acc_sum >>> 2);
      push_data.sym   = cap_idx;
      push            = pipe_out && !kill && (grp == 2'd3);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         grp <= 2'd0;
      end else if (state == CLEAR || kill) begin
         acc <= '0;
         grp <= 2'd0;
      end else if (pipe_out) begin
         grp <= grp + 2'd1;
         acc <= (grp == 2'd3) ? '0 : acc_sum;
      end
   end
`else
   always_comb begin
      push_data.theta = theta_in;
      push_data.eps   = eps_in;
      push_data.sym   = cap_idx;
      push            = pipe_out && !kill;
   end
`endif

   est_res_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (dp_clr),
      .push      (push),
      .push_data (push_data),
      .ready     (res.res_ready),
      .valid     (res.res_valid),
      .head      (head),
      .drop      (drop)
   );

   assign res.res_theta = head.theta;
   assign res.res_eps   = head.eps;
   assign res.res_sym   = head.sym;

endmodule

// File: tb/tb_est_seq_ctrl.sv
// Directed bench for est_seq_ctrl: control-vector table plus acquisition,
// overrun, abort and asynchronous-reset sequences.
module tb_est_seq_ctrl;
   import data_type::*;

`ifdef EST_SEQ_CTRL_EPS_AVG_EN
   localparam int NSYM = 4;
   localparam bit AVG  = 1'b1;
`else
   localparam int NSYM = 3;
   localparam bit AVG  = 1'b0;
`endif
   localparam int FULL_SAMPLES = FIRST_SAMPLES + (NSYM - 1) * N;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   start = 1'b0;
   logic   abort = 1'b0;
   logic   in_valid = 1'b0;
   theta_t theta_in = '0;
   eps_t   eps_in = '0;
   logic   dp_clr, dp_en, win_last, busy, done, overrun;

   est_seq_ctrl_if res_if ();

   est_seq_ctrl #(.NUM_SYM(NSYM)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .theta_in (theta_in),
      .eps_in   (eps_in),
      .dp_clr   (dp_clr),
      .dp_en    (dp_en),
      .win_last (win_last),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun),
      .res      (res_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit st, ab, iv;
      bit e_clr, e_en, e_busy, e_done, e_rv;
   } vec_t;

   typedef struct {
      int     t;
      sym_t   sym;
      theta_t th;
      eps_t   ep;
   } pop_t;

   int   vecs = 0;
   int   miss = 0;
   int   tcyc = 0;
   int   k_start = 0;
   int   nended = 0;
   int   en_err = 0;
   bit   act = 1'b0;
   int   c_win[4];
   int   wl_q[$];
   int   done_q[$];
   int   clr_q[$];
   pop_t pop_q[$];
   eps_t avg_tab[4];
   vec_t tab[11];

   function automatic theta_t th_f(input int t);
      return theta_t'(t);
   endfunction

   function automatic eps_t ep_f(input int t);
      return eps_t'(t * 5 + 1000);
   endfunction

   function automatic pop_t get_pop(input int i);
      pop_t p;
      p = '{-1, '0, '0, '0};
      if (i < pop_q.size()) p = pop_q[i];
      return p;
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then observe outputs.
   task automatic tick(input bit iv, input bit st, input bit ab, input bit rdy);
      @(negedge clk);
      tcyc++;
      in_valid = iv;
      start = st;
      abort = ab;
      res_if.res_ready = rdy;
      theta_in = th_f(tcyc);
      if (AVG) eps_in = (nended > 0) ? avg_tab[nended-1] : '0;
      else     eps_in = ep_f(tcyc);
      #1;
      if (win_last) wl_q.push_back(tcyc);
      if (done)     done_q.push_back(tcyc);
      if (dp_clr)   clr_q.push_back(tcyc);
      if (res_if.res_valid && rdy)
         pop_q.push_back('{tcyc, res_if.res_sym, res_if.res_theta, res_if.res_eps});
      if (dp_en !== (iv && act)) en_err++;
   endtask

   task automatic check_reset(input string nm);
      check({nm, "_ctl"}, {57'd0, dp_clr, dp_en, win_last, busy, done, overrun, res_if.res_valid}, 64'd0);
      check({nm, "_theta"}, 64'(res_if.res_theta), 64'd0);
      check({nm, "_eps"}, 64'(res_if.res_eps), 64'd0);
      check({nm, "_sym"}, 64'(res_if.res_sym), 64'd0);
   endtask

   // start, CLEAR, then feed samples until stop_at accepted; stays busy afterwards.
   task automatic run(input bit rdy, input bit tog, input int stop_at);
      int acc = 0;
      int guard = 0;
      bit ph = 1'b1;
      bit iv;
      wl_q.delete(); done_q.delete(); clr_q.delete(); pop_q.delete();
      en_err = 0;
      nended = 0;
      act = 1'b0;
      tick(1'b0, 1'b1, 1'b0, rdy);
      k_start = tcyc;
      tick(1'b0, 1'b0, 1'b0, rdy);
      act = 1'b1;
      while (acc < stop_at && guard < 6000) begin
         iv = tog ? ph : 1'b1;
         ph = ~ph;
         tick(iv, 1'b0, 1'b0, rdy);
         guard++;
         if (iv) begin
            acc++;
            for (int i = 0; i < NSYM; i++)
               if (acc == FIRST_SAMPLES + i * N) begin
                  c_win[i] = tcyc;
                  nended++;
               end
         end
      end
      if (guard >= 6000) check("run_budget", 64'(acc), 64'(stop_at));
   endtask

   task automatic run_full(input bit rdy, input bit tog);
      run(rdy, tog, FULL_SAMPLES);
      act = 1'b0;
      repeat (20) tick(1'b1, 1'b0, 1'b0, rdy);
   endtask

   task automatic check_full(input string nm);
      pop_t p;
      int   c;
      check({nm, "_wl_n"}, 64'(wl_q.size()), 64'(NSYM));
      for (int i = 0; i < NSYM; i++)
         check($sformatf("%s_wl%0d", nm, i), 64'((i < wl_q.size()) ? wl_q[i] : -1), 64'(c_win[i] + 1));
      if (AVG) begin
         c = c_win[3];
         p = get_pop(0);
         check({nm, "_pop_n"}, 64'(pop_q.size()), 64'd1);
         check({nm, "_avg_t"}, 64'(p.t), 64'(c + 14));
         check({nm, "_avg_sym"}, 64'(p.sym), 64'd3);
         check({nm, "_avg_eps"}, 64'(p.ep), 64'(eps_t'(51)));
         check({nm, "_avg_theta"}, 64'(p.th), 64'(th_f(c + 13)));
      end else begin
         check({nm, "_pop_n"}, 64'(pop_q.size()), 64'(NSYM));
         for (int i = 0; i < NSYM; i++) begin
            p = get_pop(i);
            c = c_win[i];
            check($sformatf("%s_t%0d", nm, i), 64'(p.t), 64'(c + 14));
            check($sformatf("%s_sym%0d", nm, i), 64'(p.sym), 64'(i));
            check($sformatf("%s_theta%0d", nm, i), 64'(p.th), 64'(th_f(c + 13)));
            check($sformatf("%s_eps%0d", nm, i), 64'(p.ep), 64'(ep_f(c + 13)));
         end
      end
      check({nm, "_done_n"}, 64'(done_q.size()), 64'd1);
      check({nm, "_done_t"}, 64'((done_q.size() > 0) ? done_q[0] : -1), 64'(c_win[NSYM-1] + 14));
      check({nm, "_clr_n"}, 64'(clr_q.size()), 64'd1);
      check({nm, "_clr_t"}, 64'((clr_q.size() > 0) ? clr_q[0] : -1), 64'(k_start + 1));
      check({nm, "_dp_en"}, 64'(en_err), 64'd0);
      check({nm, "_busy"}, 64'(busy), 64'd0);
      check({nm, "_ovr"}, 64'(overrun), 64'd0);
   endtask

   initial begin
      avg_tab = '{eps_t'(100), eps_t'(101), eps_t'(-3), eps_t'(6)};
      //        st ab iv  clr en busy done rv
      tab = '{
         '{0, 0, 1,  0, 0, 0, 0, 0},   // IDLE ignores in_valid
         '{1, 1, 0,  0, 0, 0, 0, 0},   // start with abort
         '{0, 0, 0,  0, 0, 0, 0, 0},   // ...was ignored
         '{1, 0, 1,  0, 0, 0, 0, 0},   // start sampled
         '{0, 0, 1,  1, 0, 1, 0, 0},   // CLEAR
         '{0, 0, 1,  0, 1, 1, 0, 0},   // FILL
         '{0, 0, 0,  0, 0, 1, 0, 0},
         '{1, 0, 1,  0, 1, 1, 0, 0},   // start while busy
         '{0, 0, 0,  0, 0, 1, 0, 0},   // no second CLEAR
         '{0, 1, 1,  0, 1, 1, 0, 0},   // abort
         '{0, 0, 1,  0, 0, 0, 0, 0}    // IDLE next cycle, no done
      };

      res_if.res_ready = 1'b0;
      in_valid = 1'b1;
      #1 rst = 1'b0;
      #2 check_reset("rst0");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         tick(tab[i].iv, tab[i].st, tab[i].ab, 1'b1);
         check($sformatf("vec%0d", i),
               {59'd0, dp_clr, dp_en, busy, done, res_if.res_valid},
               {59'd0, tab[i].e_clr, tab[i].e_en, tab[i].e_busy, tab[i].e_done, tab[i].e_rv});
      end

      run_full(1'b1, 1'b0);
      check_full("cont");
      run_full(1'b1, 1'b1);
      check_full("tog");

      if (!AVG) begin
         pop_t p;
         run_full(1'b0, 1'b0);
         check("ovr_set", 64'(overrun), 64'd1);
         check("ovr_valid", 64'(res_if.res_valid), 64'd1);
         check("ovr_done_n", 64'(done_q.size()), 64'd1);
         tick(1'b0, 1'b0, 1'b0, 1'b1);
         tick(1'b0, 1'b0, 1'b0, 1'b1);
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         check("ovr_empty", 64'(res_if.res_valid), 64'd0);
         check("ovr_pop_n", 64'(pop_q.size()), 64'd2);
         for (int i = 0; i < 2; i++) begin
            p = get_pop(i);
            check($sformatf("ovr_sym%0d", i), 64'(p.sym), 64'(i));
            check($sformatf("ovr_theta%0d", i), 64'(p.th), 64'(th_f(c_win[i] + 13)));
         end
         check("ovr_sticky", 64'(overrun), 64'd1);
      end

      // abort on accepted sample 600 (inside window 1)
      run(1'b0, 1'b0, 590);
      check("abt_ovr_clr", 64'(overrun), 64'd0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (8) tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      act = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("abt_idle", 64'(busy), 64'd0);
      repeat (30) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("abt_clr_n", 64'(clr_q.size()), 64'd1);
      check("abt_wl_n", 64'(wl_q.size()), 64'd1);
      check("abt_done_n", 64'(done_q.size()), 64'd0);
      check("abt_dp_en", 64'(en_err), 64'd0);
      check("abt_kept", 64'(res_if.res_valid), 64'(!AVG));
      if (!AVG) begin
         tick(1'b0, 1'b0, 1'b0, 1'b1);
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         check("abt_pop_n", 64'(pop_q.size()), 64'd1);
         check("abt_pop_sym", 64'(get_pop(0).sym), 64'd0);
         check("abt_empty", 64'(res_if.res_valid), 64'd0);
      end

      // asynchronous reset between edges while in TRACK
      run(1'b0, 1'b0, 700);
      check("pre_rst_busy", 64'(busy), 64'd1);
      check("pre_rst_valid", 64'(res_if.res_valid), 64'(!AVG));
      @(negedge clk);
      in_valid = 1'b1;
      #2 rst = 1'b0;
      #1 check_reset("rst_mid");
      @(negedge clk);
      rst = 1'b1;
      act = 1'b0;
      repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_idle", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/est_seq_ctrl.md
# est_seq_ctrl

Sequencer for the CP-based ML timing/CFO estimator datapath (delay line, phi/gamma sums, mag/angle, minus, argmax). Arms an acquisition on request, clears and enables the datapath, counts samples into the first 2N+L window and subsequent N-sample windows, and restarts the argmax per window. Captures each theta/epsilon result after the datapath pipeline delay into a 2-entry result buffer with a valid/ready output. Sits between the receiver front-end control and the estimator core; replaces free-running valid generation.

## Interface
- N, 256, samples per OFDM symbol (power of two)
- L, 16, cyclic-prefix length
- PIPE_DELAY, 12, cycles from window-end pulse to a stable theta/epsilon at the argmax outputs
- NUM_SYM, 0, windows per acquisition; 0 = continuous until abort
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  arm acquisition; honoured only in IDLE
- abort  in  1  terminate acquisition; highest priority after reset
- in_valid  in  1  front-end sample strobe
- theta_in  in  $bits(theta_t)  argmax theta
- eps_in  in  $bits(eps_t)  argmax epsilon
- dp_clr  out  1  one-cycle synchronous clear to datapath accumulators and delay line
- dp_en  out  1  datapath sample enable = in_valid qualified by FILL/TRACK
- win_last  out  1  one-cycle argmax restart / window-end pulse
- res_valid  out  1  result buffer non-empty
- res_ready  in  1  consumer accepts head entry
- res_theta  out  $bits(theta_t)  head theta
- res_eps  out  $bits(eps_t)  head epsilon
- res_sym  out  16  window index of head result, first window = 0
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN -> IDLE
- overrun  out  1  sticky; set on dropped result, cleared by start

## Operation
- States: IDLE, CLEAR, FILL, TRACK, DRAIN.
- IDLE: start -> CLEAR. in_valid ignored.
- CLEAR: one cycle; dp_clr=1; sample and window counters zeroed; overrun cleared; delay pipe and result buffer flushed -> FILL.
- FILL: dp_en=in_valid; count accepted samples; on accept of sample 2N+L (528) -> TRACK, counter resets.
- TRACK: dp_en=in_valid; on each Nth accepted sample the window ends; window counter (16-bit, wraps) increments. If NUM_SYM != 0 and the ended window count equals NUM_SYM -> DRAIN.
- Window end (FILL exit or TRACK boundary): win_last registered high next cycle; win_last enters a PIPE_DELAY shift pipe; pipe output captures {theta_in, eps_in, window index} into the buffer.
- DRAIN: dp_en=0; waits until the delay pipe is empty and the final capture is done; then done=1 -> IDLE. Buffer contents persist in IDLE.
- Buffer: 2-entry FIFO; pop on res_valid&res_ready. Push and pop in the same cycle is always accepted, including when full. Push while full without a pop: new result dropped, overrun set.
- abort, any non-IDLE state: -> IDLE next cycle; delay pipe cleared; buffer kept; no done pulse. abort and start in the same cycle in IDLE: start ignored.
- start in non-IDLE: ignored.
- Counters are sized $clog2(2N+L); the N-window compare uses mask N-1.

## Timing
- Reset values: dp_clr=0, dp_en=0, win_last=0, res_valid=0, res_theta=0, res_eps=0, res_sym=0, busy=0, done=0, overrun=0; state IDLE.
- start sampled at edge k: CLEAR during cycle k+1, FILL from k+2.
- Sample accepted in cycle c ends a window: win_last in c+1; capture at the end of c+1+PIPE_DELAY; res_valid in c+2+PIPE_DELAY (14 cycles at default).
- dp_en is combinational from in_valid and state, with no added latency.
- Window spacing in TRACK is exactly N accepted samples, independent of in_valid gaps.

## Configuration
- EST_SEQ_CTRL_EPS_AVG_EN defined: epsilon results are summed in an EPS_W+2 signed accumulator over 4 consecutive windows. One buffer push per 4 windows, with eps = sum >>> 2 (arithmetic, truncating), theta of the 4th window, and index of the 4th window. The partial accumulator is discarded on abort/CLEAR. In DRAIN, a partial group (<4) is dropped.
- Not defined: one push per window, raw eps_in.

## Structure
- Package data_type holds theta_t and eps_t, plus shared constants N, L, PIPE_DELAY, FIRST_SAMPLES=2N+L, and the est_state_e enum.
- One sub-module, est_res_fifo: a 2-entry FIFO with full/empty and a simultaneous push/pop rule. FSM, counters, and the delay pipe live in est_seq_ctrl.

## Test plan
- Reset mid-TRACK, with rst low asynchronously between edges -> all outputs go to reset values immediately; IDLE.
- start, continuous in_valid, NUM_SYM=3, res_ready=1 -> dp_clr one cycle; win_last after samples 528, 784, 1040; res_valid 14 cycles after each sample; res_sym 0, 1, 2; done once.
- Same run with in_valid toggling 1/0 -> boundaries still fall on accepted samples 528/784/1040; dp_en mirrors in_valid only in FILL/TRACK.
- res_ready=0, NUM_SYM=3 -> two results buffered, third dropped, overrun=1; subsequent pops return indices 0, 1.
- abort at sample 600 -> IDLE next cycle; no capture for the aborted window; buffer retained; start while busy is ignored.
- EST_SEQ_CTRL_EPS_AVG_EN, eps_in 100, 101, -3, 6 over windows 0–3 -> single result eps=51, res_sym=3.
